// File: rtl/key_pkg.sv
// Shared definitions for the push-button debounce / event logic:
// per-channel state encoding, default 50 MHz timing constants and a
// small helper used when sizing the repeat counter.
package key_pkg;

    // Debounce state of one key channel
    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    // Default timing at a 50 MHz system clock
    localparam int KEY_STABLE_10MS         = 500_000;
    localparam int KEY_REPEAT_DELAY_500MS  = 25_000_000;
    localparam int KEY_REPEAT_PERIOD_100MS = 5_000_000;

    // Larger of two integers, used to size counters shared by two limits
    function automatic int keyMax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_event_channel.sv
// One debounced key channel: takes the polarity-normalised raw level,
// qualifies level changes over STABLE_CYCLES consecutive samples and
// produces a clean level plus press, release and auto-repeat pulses.
// All outputs come straight from flops.
module key_event_channel
    import key_pkg::*;
#(
    parameter int STABLE_CYCLES = KEY_STABLE_10MS,
    parameter int REPEAT_DELAY  = KEY_REPEAT_DELAY_500MS,
    parameter int REPEAT_PERIOD = KEY_REPEAT_PERIOD_100MS
) (
    input  logic clock,
    input  logic reset_n,
    input  logic pressedRaw_i,
    output logic keyLevel_o,
    output logic keyPress_o,
    output logic keyRelease_o,
    output logic keyRepeat_o
);

    localparam int SW      = $clog2(STABLE_CYCLES + 1);
    localparam int REP_MAX = keyMax(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int RW      = $clog2(REP_MAX + 1);

    localparam logic [SW-1:0] STABLE_TARGET = SW'(STABLE_CYCLES);
    localparam logic [RW-1:0] DELAY_TARGET  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] PERIOD_TARGET = RW'(REPEAT_PERIOD);
    localparam logic [RW-1:0] REP_LIMIT     = RW'(REP_MAX);
    localparam logic          REPEAT_EN     = (REPEAT_DELAY != 0);

    key_state_t      state_q;
    logic [SW-1:0]   stableCnt_q;
    logic [RW-1:0]   repCnt_q;
    logic            repFirstDone_q;
    logic            keyLevel_q;
    logic            keyPress_q;
    logic            keyRelease_q;
    logic            keyRepeat_q;

    logic [SW-1:0]   stableInc_d;
    logic [RW-1:0]   repInc_d;
    logic [RW-1:0]   repTarget_d;
    logic [RW-1:0]   repCnt_d;
    logic            repFirstDone_d;
    logic            repFire_d;

    // Saturating counter increments and the next step of the repeat timer;
    // the first pulse waits REPEAT_DELAY, every later one REPEAT_PERIOD
    always_comb begin
        stableInc_d    = (stableCnt_q == STABLE_TARGET) ? stableCnt_q : stableCnt_q + SW'(1);
        repInc_d       = (repCnt_q == REP_LIMIT) ? repCnt_q : repCnt_q + RW'(1);
        repTarget_d    = repFirstDone_q ? PERIOD_TARGET : DELAY_TARGET;
        repCnt_d       = repInc_d;
        repFirstDone_d = repFirstDone_q;
        repFire_d      = 1'b0;
        if (REPEAT_EN && (repInc_d == repTarget_d)) begin
            repCnt_d       = '0;
            repFirstDone_d = 1'b1;
            repFire_d      = 1'b1;
        end
    end

    // Channel FSM with registered level and one-cycle event pulses;
    // the repeat timer only advances while the key is accepted as held
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q        <= RELEASED;
            stableCnt_q    <= '0;
            repCnt_q       <= '0;
            repFirstDone_q <= 1'b0;
            keyLevel_q     <= 1'b0;
            keyPress_q     <= 1'b0;
            keyRelease_q   <= 1'b0;
            keyRepeat_q    <= 1'b0;
        end else begin
            keyPress_q   <= 1'b0;
            keyRelease_q <= 1'b0;
            keyRepeat_q  <= 1'b0;
            case (state_q)
                RELEASED: begin
                    if (pressedRaw_i) begin
                        state_q     <= PRESS_WAIT;
                        stableCnt_q <= SW'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!pressedRaw_i) begin
                        state_q     <= RELEASED;
                        stableCnt_q <= '0;
                    end else if (stableInc_d == STABLE_TARGET) begin
                        state_q        <= PRESSED;
                        stableCnt_q    <= '0;
                        keyLevel_q     <= 1'b1;
                        keyPress_q     <= 1'b1;
                        repCnt_q       <= '0;
                        repFirstDone_q <= 1'b0;
                    end else begin
                        stableCnt_q <= stableInc_d;
                    end
                end
                PRESSED: begin
                    if (!pressedRaw_i) begin
                        state_q     <= RELEASE_WAIT;
                        stableCnt_q <= SW'(1);
                    end
                    repCnt_q       <= repCnt_d;
                    repFirstDone_q <= repFirstDone_d;
                    keyRepeat_q    <= repFire_d;
                end
                RELEASE_WAIT: begin
                    if (pressedRaw_i) begin
                        state_q        <= PRESSED;
                        stableCnt_q    <= '0;
                        repCnt_q       <= repCnt_d;
                        repFirstDone_q <= repFirstDone_d;
                        keyRepeat_q    <= repFire_d;
                    end else if (stableInc_d == STABLE_TARGET) begin
                        state_q        <= RELEASED;
                        stableCnt_q    <= '0;
                        keyLevel_q     <= 1'b0;
                        keyRelease_q   <= 1'b1;
                        repCnt_q       <= '0;
                        repFirstDone_q <= 1'b0;
                    end else begin
                        stableCnt_q    <= stableInc_d;
                        repCnt_q       <= repCnt_d;
                        repFirstDone_q <= repFirstDone_d;
                        keyRepeat_q    <= repFire_d;
                    end
                end
                default: begin
                    state_q     <= RELEASED;
                    stableCnt_q <= '0;
                end
            endcase
        end
    end

    assign keyLevel_o   = keyLevel_q;
    assign keyPress_o   = keyPress_q;
    assign keyRelease_o = keyRelease_q;
    assign keyRepeat_o  = keyRepeat_q;

endmodule

// File: rtl/key_event_filter.sv
// Debounce and event generation for WIDTH independent push-buttons fed
// from the input synchroniser. Normalises key polarity so 1 = pressed,
// then hands each bit to its own key_event_channel.
module key_event_filter
    import key_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int ACTIVE_LOW    = 1,
    parameter int STABLE_CYCLES = KEY_STABLE_10MS,
    parameter int REPEAT_DELAY  = KEY_REPEAT_DELAY_500MS,
    parameter int REPEAT_PERIOD = KEY_REPEAT_PERIOD_100MS
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] syncIn,
    output logic [WIDTH-1:0] keyLevel,
    output logic [WIDTH-1:0] keyPress,
    output logic [WIDTH-1:0] keyRelease,
    output logic [WIDTH-1:0] keyRepeat
);

    localparam logic POLARITY = (ACTIVE_LOW != 0);

    logic [WIDTH-1:0] pressedRaw;

    assign pressedRaw = syncIn ^ {WIDTH{POLARITY}};

    for (genvar ch = 0; ch < WIDTH; ch++) begin : g_channel
        key_event_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_channel (
            .clock        (clock),
            .reset_n      (reset_n),
            .pressedRaw_i (pressedRaw[ch]),
            .keyLevel_o   (keyLevel[ch]),
            .keyPress_o   (keyPress[ch]),
            .keyRelease_o (keyRelease[ch]),
            .keyRepeat_o  (keyRepeat[ch])
        );
    end

endmodule

// File: tb/tb_key_event_filter.sv
// Scoreboard bench for key_event_filter with short timing constants.
// Stimulus pushes every expected output event (edge number plus full
// output vectors) into a queue; a monitor pops one entry whenever the DUT
// shows a pulse or a level change and compares it.
module tb_key_event_filter;

    logic       clock;
    logic       reset_n;
    logic [3:0] syncIn;
    logic [3:0] keyLevel;
    logic [3:0] keyPress;
    logic [3:0] keyRelease;
    logic [3:0] keyRepeat;

    typedef struct {
        int         edgeNo;
        logic [3:0] level;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] rpt;
    } exp_t;

    exp_t sbQueue[$];
    exp_t expItem;
    int   cycleCnt   = 0;
    int   compared   = 0;
    int   mismatched = 0;
    int   eventNo    = 0;
    int   c;
    logic [3:0] prevLevel = 4'h0;

    key_event_filter #(
        .WIDTH         (4),
        .ACTIVE_LOW    (1),
        .STABLE_CYCLES (4),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (3)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .syncIn     (syncIn),
        .keyLevel   (keyLevel),
        .keyPress   (keyPress),
        .keyRelease (keyRelease),
        .keyRepeat  (keyRepeat)
    );

    // Free-running clock and rising-edge counter used to time-stamp events
    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cycleCnt <= cycleCnt + 1;

    // Drive inputs for a number of rising edges, returning just after a falling edge
    task automatic applyStimulus(input logic [3:0] v, input logic rstN, input int hold);
        syncIn  = v;
        reset_n = rstN;
        repeat (hold) @(negedge clock);
    endtask

    task automatic pushExp(input int e, input logic [3:0] lvl, input logic [3:0] pr,
                           input logic [3:0] rl, input logic [3:0] rp);
        exp_t item;
        item.edgeNo = e;
        item.level  = lvl;
        item.press  = pr;
        item.rel    = rl;
        item.rpt    = rp;
        sbQueue.push_back(item);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, required %h (edge %0d)", name, actual, required, cycleCnt);
        end
    endtask

    // Monitor: any pulse or level change is an output event matched against the queue
    always @(negedge clock) begin
        if (reset_n !== 1'bx && cycleCnt > 1) begin
            if ((keyLevel !== prevLevel) || (|keyPress) || (|keyRelease) || (|keyRepeat)) begin
                compared++;
                eventNo++;
                if (sbQueue.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL unexpectedEvent%0d: got edge=%0d lvl=%b prs=%b rel=%b rpt=%b, required no event",
                             eventNo, cycleCnt, keyLevel, keyPress, keyRelease, keyRepeat);
                end else begin
                    expItem = sbQueue.pop_front();
                    if (expItem.edgeNo != cycleCnt || keyLevel !== expItem.level ||
                        keyPress !== expItem.press || keyRelease !== expItem.rel ||
                        keyRepeat !== expItem.rpt) begin
                        mismatched++;
                        $display("[TB] FAIL event%0d: got edge=%0d lvl=%b prs=%b rel=%b rpt=%b, required edge=%0d lvl=%b prs=%b rel=%b rpt=%b",
                                 eventNo, cycleCnt, keyLevel, keyPress, keyRelease, keyRepeat,
                                 expItem.edgeNo, expItem.level, expItem.press, expItem.rel, expItem.rpt);
                    end
                end
            end
        end
        prevLevel = keyLevel;
    end

    // Safety net so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios; expected events are queued before each is driven
    initial begin
        syncIn  = 4'hF;
        reset_n = 1'b0;
        @(negedge clock);
        applyStimulus(4'hF, 1'b0, 3);
        checkOutput("resetOutputs", {keyLevel, keyPress, keyRelease, keyRepeat}, 16'h0000);
        applyStimulus(4'hF, 1'b1, 3);

        // Key 0: clean press, repeats, 3-cycle release glitch, release colliding with a repeat slot
        c = cycleCnt;
        pushExp(c + 4, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        pushExp(c + 14, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        pushExp(c + 17, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        pushExp(c + 20, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        pushExp(c + 23, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        pushExp(c + 26, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        pushExp(c + 29, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        applyStimulus(4'hE, 1'b1, 12);
        applyStimulus(4'hF, 1'b1, 3);
        checkOutput("glitchLevelHeld", {12'h0, keyLevel}, 16'h0001);
        applyStimulus(4'hE, 1'b1, 10);
        checkOutput("afterGlitchLevel", {12'h0, keyLevel}, 16'h0001);
        applyStimulus(4'hF, 1'b1, 8);

        // Key 1: bounce pattern 0,0,0,1 never qualifies, then a clean 4-sample press
        for (int i = 0; i < 6; i++) begin
            applyStimulus(4'hD, 1'b1, 3);
            applyStimulus(4'hF, 1'b1, 1);
        end
        checkOutput("bounceLevel", {12'h0, keyLevel}, 16'h0000);
        c = cycleCnt;
        pushExp(c + 4, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
        pushExp(c + 8, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
        applyStimulus(4'hD, 1'b1, 4);
        applyStimulus(4'hF, 1'b1, 8);

        // Key 2: long hold with auto-repeat; release lands on a would-be repeat edge
        c = cycleCnt;
        pushExp(c + 4, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
        for (int j = 0; j < 12; j++)
            pushExp(c + 14 + 3 * j, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
        pushExp(c + 50, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
        applyStimulus(4'hB, 1'b1, 46);
        applyStimulus(4'hF, 1'b1, 8);

        // Key 3: reset on the 3rd sample of qualification, then fresh qualification
        c = cycleCnt;
        applyStimulus(4'h7, 1'b1, 2);
        applyStimulus(4'h7, 1'b0, 1);
        checkOutput("resetMidQualify", {keyLevel, keyPress, keyRelease, keyRepeat}, 16'h0000);
        pushExp(c + 7, 4'b1000, 4'b1000, 4'b0000, 4'b0000);
        pushExp(c + 11, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
        applyStimulus(4'h7, 1'b1, 4);
        applyStimulus(4'hF, 1'b1, 8);

        // All four keys pressed and released on the same edges
        c = cycleCnt;
        pushExp(c + 4, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
        pushExp(c + 9, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
        applyStimulus(4'h0, 1'b1, 5);
        applyStimulus(4'hF, 1'b1, 8);

        // Key 0 held through a mid-repeat reset: level drops, no stale repeat, full requalification
        c = cycleCnt;
        pushExp(c + 4, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        pushExp(c + 14, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        pushExp(c + 16, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        pushExp(c + 20, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        pushExp(c + 24, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        applyStimulus(4'hE, 1'b1, 15);
        applyStimulus(4'hE, 1'b0, 1);
        applyStimulus(4'hE, 1'b1, 4);
        applyStimulus(4'hF, 1'b1, 8);

        // Bounded drain of anything still expected
        for (int w = 0; w < 50 && sbQueue.size() != 0; w++)
            @(negedge clock);
        while (sbQueue.size() != 0) begin
            expItem = sbQueue.pop_front();
            compared++;
            mismatched++;
            $display("[TB] FAIL missingEvent: got nothing, required edge=%0d lvl=%b prs=%b rel=%b rpt=%b",
                     expItem.edgeNo, expItem.level, expItem.press, expItem.rel, expItem.rpt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/key_event_filter.md
# key_event_filter

Per-key debounce and event generator that sits directly downstream of the two-flop input synchroniser on the DE1-SoC push-buttons. It consumes the already-synchronised, still-bouncy key levels and produces a clean pressed level plus single-cycle press, release and auto-repeat pulses. The game FSM and paddle controllers use these pulses for serve, pause and paddle-step commands.

## Interface
Parameters:
- WIDTH, 4: number of independent key channels.
- ACTIVE_LOW, 1: 1 means a raw input of 0 is "pressed" (the DE1-SoC KEY convention); 0 means a raw 1 is "pressed".
- STABLE_CYCLES, 500000: consecutive identical samples needed to accept a level change (10 ms at 50 MHz). Must be ≥ 2.
- REPEAT_DELAY, 25000000: cycles from the press pulse to the first repeat pulse. 0 disables auto-repeat.
- REPEAT_PERIOD, 5000000: cycles between later repeat pulses. Must be ≥ 1.

Ports:
- clock, input, 1: system clock. All logic is on the rising edge.
- reset_n, input, 1: synchronous, active-low reset.
- syncIn, input, WIDTH: synchroniser output; raw key levels.
- keyLevel, output, WIDTH: debounced pressed state, 1 = pressed.
- keyPress, output, WIDTH: one-cycle pulse on an accepted press.
- keyRelease, output, WIDTH: one-cycle pulse on an accepted release.
- keyRepeat, output, WIDTH: one-cycle auto-repeat pulse while a key is held.

## Operation
- Each bit is fully independent. Channels never interact.
- Polarity normalisation: pressedRaw = syncIn XOR {WIDTH{ACTIVE_LOW}}.
- Per-channel FSM states:
  - RELEASED: if pressedRaw=1, go to PRESS_WAIT with stableCnt=1.
  - PRESS_WAIT: if pressedRaw=0, go back to RELEASED with stableCnt=0. Otherwise increment stableCnt. When stableCnt reaches STABLE_CYCLES, go to PRESSED, set keyLevel=1, pulse keyPress, and clear repCnt.
  - PRESSED: if pressedRaw=0, go to RELEASE_WAIT with stableCnt=1. Otherwise run repCnt.
  - RELEASE_WAIT: if pressedRaw=1, go back to PRESSED with stableCnt=0. repCnt keeps running, so a glitch does not restart repeat timing. Otherwise increment stableCnt. When stableCnt reaches STABLE_CYCLES, go to RELEASED, set keyLevel=0, pulse keyRelease.
- Auto-repeat, only when REPEAT_DELAY≠0:
  - repCnt counts every cycle in PRESSED or RELEASE_WAIT.
  - keyRepeat pulses when repCnt reaches REPEAT_DELAY; repCnt then reloads so the next pulse comes REPEAT_PERIOD cycles later, and so on.
  - A repeat pulse is never issued in the same cycle as keyPress or keyRelease.
  - Repeat pulses stop in the cycle keyRelease fires.
- Width rules:
  - stableCnt width is $clog2(STABLE_CYCLES+1). It saturates and never wraps.
  - repCnt width is $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1).
- Reset (reset_n=0 at a clock edge): all channels go to RELEASED, counters clear, and all outputs are 0. A key held through reset must still pass the full STABLE_CYCLES qualification afterwards before keyPress fires.
- Reset asserted mid-qualification or mid-repeat discards all progress. No pulse is emitted for the interrupted event.

## Timing
- All outputs are registered. No combinational path runs from syncIn to any output.
- Press latency: if pressedRaw=1 is sampled at edges k … k+N−1 (N=STABLE_CYCLES), keyLevel and keyPress go high after edge k+N−1. keyPress is high for exactly one cycle.
- Release latency is symmetric, with keyLevel falling at the same edge keyRelease rises.
- A glitch of N−1 or fewer samples produces no output change.
- First keyRepeat comes REPEAT_DELAY cycles after the keyPress cycle. Later pulses follow every REPEAT_PERIOD cycles.
- Minimum spacing between keyPress and keyRelease on one channel is N cycles.
- Outputs of different channels may pulse in the same cycle.

## Structure
- Shared package key_pkg holds:
  - the state encoding typedef (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT);
  - the default timing constants for 50 MHz: KEY_STABLE_10MS, KEY_REPEAT_DELAY_500MS, KEY_REPEAT_PERIOD_100MS.
- One sub-module, key_event_channel, implements a single channel (FSM, stableCnt, repCnt). The top module instantiates it WIDTH times in a generate loop and does the polarity XOR.

## Test plan
All scenarios use WIDTH=4, ACTIVE_LOW=1, STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Clean press: drive syncIn[0]=0 from edge 10 onward. Required: keyLevel[0] and a one-cycle keyPress[0] after edge 13, and no other bits change.
- Bounce rejection: drive syncIn[1] as 0,0,0,1,0,0,0,1 repeatedly. Required: keyLevel[1] stays 0 and no pulses occur. Then hold 0 for 4 cycles and check that exactly one keyPress[1] fires.
- Auto-repeat: hold syncIn[2]=0 for 40 cycles after keyPress. Required: keyRepeat[2] at +10, +13, +16 … cycles. Release, and check that keyRelease fires 4 cycles later with no repeat in that cycle.
- Release glitch: while pressed, pulse syncIn[0]=1 for 3 cycles. Required: keyLevel stays 1, there is no keyRelease, and repeat spacing is unchanged.
- Reset mid-qualification: set syncIn[3]=0 and assert reset_n=0 at the 3rd sample. Required: all outputs stay 0. keyPress[3] fires only after 4 fresh samples following reset release.
- Simultaneous events: press all 4 keys on the same edge. Required: all four keyPress bits pulse in the same cycle.
